// File: rtl/fft_frame_seq.sv
// fft_frame_seq: frame sequencer around a streaming FFT core.
// Loads FFT_MAX samples into the core, waits for the core's result burst,
// and re-emits the FFT_MAX bins with bin index, last flag and done pulse.
//
// Handshake: an input sample transfers on a rising edge where s_valid and
// s_ready are both 1. s_ready depends only on the FSM state (high in LOAD),
// never on s_valid. The result stream (m_*) has no backpressure: m_valid is
// a one-cycle strobe per bin. The core side (fft_ien in, fft_oen out) is
// strobe-only.
module fft_frame_seq #(
  parameter int STAGE      = 10,
  parameter int REAL_WIDTH = 16,
  parameter int IMGN_WIDTH = 16,
  parameter int TMO_CYC    = 65535
) (
  input  logic                  iclk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  abort,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [REAL_WIDTH-1:0] s_real,
  input  logic [IMGN_WIDTH-1:0] s_imag,
  output logic [STAGE-1:0]      fft_iaddr,
  output logic [REAL_WIDTH-1:0] fft_iReal,
  output logic [IMGN_WIDTH-1:0] fft_iImag,
  output logic                  fft_ien,
  input  logic [REAL_WIDTH-1:0] fft_oReal,
  input  logic [IMGN_WIDTH-1:0] fft_oImag,
  input  logic [STAGE-1:0]      fft_oaddr,
  input  logic                  fft_oen,
  output logic                  m_valid,
  output logic [REAL_WIDTH-1:0] m_real,
  output logic [IMGN_WIDTH-1:0] m_imag,
  output logic [STAGE-1:0]      m_bin,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  tmo_err,
  output logic [15:0]           frame_cnt,
  output logic [1:0]            dbg_state
);

  localparam int TW = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_WAIT   = 2'd2,
    S_UNLOAD = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;

  logic [STAGE-1:0]      r_load_cnt;
  logic [STAGE-1:0]      r_beat_cnt;
  logic [TW-1:0]         r_tmo_cnt;

  logic [STAGE-1:0]      r_iaddr;
  logic [REAL_WIDTH-1:0] r_ireal;
  logic [IMGN_WIDTH-1:0] r_iimag;
  logic                  r_ien;
  logic                  r_mvalid;
  logic [REAL_WIDTH-1:0] r_mreal;
  logic [IMGN_WIDTH-1:0] r_mimag;
  logic [STAGE-1:0]      r_mbin;
  logic                  r_mlast;
  logic                  r_done;
  logic                  r_tmo_err;
  logic [15:0]           r_frame_cnt;

  logic                  w_in_wu;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_last_load;
  logic                  w_last_beat;
  logic                  w_tmo;

  // The done cycle (UNLOAD with r_done) is a one-cycle epilogue: further
  // oen beats are ignored and the timeout cannot fire while leaving.
  assign w_in_wu     = (r_state == S_WAIT) || (r_state == S_UNLOAD);
  assign w_accept    = s_valid && (r_state == S_LOAD);
  assign w_beat      = fft_oen && ((r_state == S_WAIT) ||
                                   ((r_state == S_UNLOAD) && !r_done));
  assign w_last_load = w_accept && (r_load_cnt == {STAGE{1'b1}});
  assign w_last_beat = w_beat && (r_beat_cnt == {STAGE{1'b1}});
  assign w_tmo       = w_in_wu && !r_done && !fft_oen &&
                       (r_tmo_cnt == TW'(TMO_CYC - 1));

  // State register.
  always_ff @(posedge iclk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode plus state-derived outputs; abort overrides everything.
  always_comb begin
    w_next  = r_state;
    s_ready = 1'b0;
    busy    = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (w_last_load) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_tmo)       w_next = S_IDLE;
        else if (w_beat) w_next = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (r_done)     w_next = cont ? S_LOAD : S_IDLE;
        else if (w_tmo) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Datapath: sample/bin registers, frame counters, timeout and status flags.
  always_ff @(posedge iclk) begin
    if (!rst_n) begin
      r_load_cnt  <= '0;
      r_beat_cnt  <= '0;
      r_tmo_cnt   <= '0;
      r_iaddr     <= '0;
      r_ireal     <= '0;
      r_iimag     <= '0;
      r_ien       <= 1'b0;
      r_mvalid    <= 1'b0;
      r_mreal     <= '0;
      r_mimag     <= '0;
      r_mbin      <= '0;
      r_mlast     <= 1'b0;
      r_done      <= 1'b0;
      r_tmo_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_ien    <= 1'b0;
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
      r_done   <= 1'b0;
      if (abort) begin
        r_load_cnt <= '0;
        r_beat_cnt <= '0;
        r_tmo_cnt  <= '0;
      end else begin
        if (w_accept) begin
          r_ien      <= 1'b1;
          r_iaddr    <= r_load_cnt;
          r_ireal    <= s_real;
          r_iimag    <= s_imag;
          r_load_cnt <= r_load_cnt + STAGE'(1);
        end
        if (w_beat) begin
          r_mvalid   <= 1'b1;
          r_mreal    <= fft_oReal;
          r_mimag    <= fft_oImag;
          r_mbin     <= fft_oaddr;
          r_beat_cnt <= r_beat_cnt + STAGE'(1);
          if (w_last_beat) begin
            r_mlast     <= 1'b1;
            r_done      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + 16'd1;
          end
        end
        // Idle cycles between core beats; cleared outside WAIT/UNLOAD so
        // that every WAIT entry starts from zero.
        if (w_tmo || !w_in_wu || fft_oen || r_done) r_tmo_cnt <= '0;
        else                                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
        if (w_tmo) begin
          r_tmo_err  <= 1'b1;
          r_beat_cnt <= '0;
          r_load_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
          r_tmo_err <= 1'b0;
        end
      end
    end
  end

  assign fft_iaddr = r_iaddr;
  assign fft_iReal = r_ireal;
  assign fft_iImag = r_iimag;
  assign fft_ien   = r_ien;
  assign m_valid   = r_mvalid;
  assign m_real    = r_mreal;
  assign m_imag    = r_mimag;
  assign m_bin     = r_mbin;
  assign m_last    = r_mlast;
  assign done      = r_done;
  assign tmo_err   = r_tmo_err;
  assign frame_cnt = r_frame_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Bench for fft_frame_seq with STAGE=3 (8-point frames) and TMO_CYC=20.
// Stimulus drives right after the rising edge; a monitor on the falling edge
// records every fft_ien sample and every m_valid bin into observed queues,
// which each scenario compares against expected queues it builds itself.
module tb_fft_frame_seq;

  localparam int STAGE = 3;
  localparam int RW    = 16;
  localparam int IW    = 16;
  localparam int TMO   = 20;
  localparam int N     = 1 << STAGE;
  localparam int IN_W  = STAGE + RW + IW;
  localparam int OUT_W = 2 + STAGE + RW + IW;

  logic             iclk;
  logic             rst_n;
  logic             start;
  logic             cont;
  logic             abort;
  logic             s_valid;
  logic             s_ready;
  logic [RW-1:0]    s_real;
  logic [IW-1:0]    s_imag;
  logic [STAGE-1:0] fft_iaddr;
  logic [RW-1:0]    fft_iReal;
  logic [IW-1:0]    fft_iImag;
  logic             fft_ien;
  logic [RW-1:0]    fft_oReal;
  logic [IW-1:0]    fft_oImag;
  logic [STAGE-1:0] fft_oaddr;
  logic             fft_oen;
  logic             m_valid;
  logic [RW-1:0]    m_real;
  logic [IW-1:0]    m_imag;
  logic [STAGE-1:0] m_bin;
  logic             m_last;
  logic             busy;
  logic             done;
  logic             tmo_err;
  logic [15:0]      frame_cnt;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  logic [IN_W-1:0]  exp_in_q[$];
  logic [IN_W-1:0]  obs_in_q[$];
  logic [OUT_W-1:0] exp_out_q[$];
  logic [OUT_W-1:0] obs_out_q[$];

  fft_frame_seq #(
    .STAGE(STAGE), .REAL_WIDTH(RW), .IMGN_WIDTH(IW), .TMO_CYC(TMO)
  ) dut (
    .iclk(iclk), .rst_n(rst_n), .start(start), .cont(cont), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .fft_iaddr(fft_iaddr), .fft_iReal(fft_iReal), .fft_iImag(fft_iImag),
    .fft_ien(fft_ien), .fft_oReal(fft_oReal), .fft_oImag(fft_oImag),
    .fft_oaddr(fft_oaddr), .fft_oen(fft_oen), .m_valid(m_valid),
    .m_real(m_real), .m_imag(m_imag), .m_bin(m_bin), .m_last(m_last),
    .busy(busy), .done(done), .tmo_err(tmo_err), .frame_cnt(frame_cnt),
    .dbg_state(dbg_state)
  );

  // Clock.
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Monitor on the falling edge, away from the active edge.
  always @(negedge iclk) begin
    if (fft_ien) obs_in_q.push_back({fft_iaddr, fft_iReal, fft_iImag});
    if (m_valid) obs_out_q.push_back({done, m_last, m_bin, m_real, m_imag});
    if (done) done_cnt++;
    if (s_valid && s_ready) acc_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_mon();
    exp_in_q.delete();
    obs_in_q.delete();
    exp_out_q.delete();
    obs_out_q.delete();
    done_cnt = 0;
    acc_cnt  = 0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Drives n valid samples (optionally 1010 gapped); each lands at index i.
  task automatic load_samples(input int n, input bit gapped, input bit seq);
    for (int i = 0; i < n; i++) begin
      if (gapped && i > 0) begin
        s_valid = 1'b0;
        cyc();
      end
      s_valid = 1'b1;
      s_real  = seq ? RW'(i + 1) : RW'($urandom);
      s_imag  = IW'($urandom);
      exp_in_q.push_back({STAGE'(i), s_real, s_imag});
      cyc();
    end
    s_valid = 1'b0;
  endtask

  // Model core: n result beats with random gaps, random data and bin index.
  task automatic core_burst(input int n, input int max_gap);
    logic lst;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) cyc();
      fft_oen   = 1'b1;
      fft_oReal = RW'($urandom);
      fft_oImag = IW'($urandom);
      fft_oaddr = STAGE'($urandom_range(0, N - 1));
      lst       = (i == N - 1);
      exp_out_q.push_back({lst, lst, fft_oaddr, fft_oReal, fft_oImag});
      cyc();
      fft_oen = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort = 1'b0; s_valid = 1'b0;
    s_real = '0; s_imag = '0; fft_oen = 1'b0; fft_oReal = '0; fft_oImag = '0;
    fft_oaddr = '0;
    repeat (3) cyc();
    checks++;
    if ({busy, s_ready, fft_ien, m_valid, m_last, done, tmo_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b exp 0000000",
               {busy, s_ready, fft_ien, m_valid, m_last, done, tmo_err});
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_frame_cnt: got %0d exp 0", frame_cnt);
    end
    checks++;
    if ({fft_iaddr, fft_iReal, fft_iImag, m_bin, m_real, m_imag} !== '0) begin
      errors++; $display("FAIL reset_data: got %h exp 0",
                         {fft_iaddr, fft_iReal, fft_iImag, m_bin, m_real, m_imag});
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_single_frame();
    clear_mon();
    do_start();
    checks++;
    if ({busy, s_ready} !== 2'b11) begin
      errors++; $display("FAIL single_load_entry: busy,s_ready got %b exp 11", {busy, s_ready});
    end
    load_samples(N, 1'b0, 1'b1);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready_drop: got %b exp 0", s_ready);
    end
    core_burst(N, 0);
    checks++;
    if ({m_valid, m_last, done} !== 3'b111) begin
      errors++; $display("FAIL single_last_done: got %b exp 111", {m_valid, m_last, done});
    end
    exp_frames++;
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++; $display("FAIL single_frame_cnt: got %0d exp %0d", frame_cnt, exp_frames);
    end
    cyc();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL single_idle: busy,done got %b exp 00", {busy, done});
    end
    checks++;
    if (acc_cnt !== N || done_cnt !== 1) begin
      errors++; $display("FAIL single_counts: accepts %0d done %0d exp %0d 1", acc_cnt, done_cnt, N);
    end
    checks++;
    if (obs_in_q.size() !== exp_in_q.size() || obs_out_q.size() !== exp_out_q.size()) begin
      errors++; $display("FAIL single_sizes: in %0d out %0d exp %0d %0d",
                         obs_in_q.size(), obs_out_q.size(), exp_in_q.size(), exp_out_q.size());
    end
    for (int i = 0; i < exp_in_q.size() && i < obs_in_q.size(); i++) begin
      checks++;
      if (obs_in_q[i] !== exp_in_q[i]) begin
        errors++; $display("FAIL single_in[%0d]: got %h exp %h", i, obs_in_q[i], exp_in_q[i]);
      end
    end
    for (int i = 0; i < exp_out_q.size() && i < obs_out_q.size(); i++) begin
      checks++;
      if (obs_out_q[i] !== exp_out_q[i]) begin
        errors++; $display("FAIL single_out[%0d]: got %h exp %h", i, obs_out_q[i], exp_out_q[i]);
      end
    end
  endtask

  task automatic test_gapped();
    clear_mon();
    do_start();
    load_samples(N, 1'b1, 1'b0);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL gapped_ready_drop: got %b exp 0", s_ready);
    end
    core_burst(N, 3);
    cyc();
    exp_frames++;
    checks++;
    if (obs_in_q.size() !== N) begin
      errors++; $display("FAIL gapped_ien_pulses: got %0d exp %0d", obs_in_q.size(), N);
    end
    for (int i = 0; i < exp_in_q.size() && i < obs_in_q.size(); i++) begin
      checks++;
      if (obs_in_q[i] !== exp_in_q[i]) begin
        errors++; $display("FAIL gapped_in[%0d]: got %h exp %h", i, obs_in_q[i], exp_in_q[i]);
      end
    end
    checks++;
    if (obs_out_q.size() !== exp_out_q.size()) begin
      errors++; $display("FAIL gapped_out_count: got %0d exp %0d", obs_out_q.size(), exp_out_q.size());
    end
    for (int i = 0; i < exp_out_q.size() && i < obs_out_q.size(); i++) begin
      checks++;
      if (obs_out_q[i] !== exp_out_q[i]) begin
        errors++; $display("FAIL gapped_out[%0d]: got %h exp %h", i, obs_out_q[i], exp_out_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++; $display("FAIL gapped_frame_cnt: got %0d exp %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_timeout();
    int first;
    clear_mon();
    do_start();
    load_samples(N, 1'b0, 1'b0);
    first = 0;
    for (int m = 1; m <= 2 * TMO && first == 0; m++) begin
      cyc();
      if (tmo_err === 1'b1) first = m;
    end
    checks++;
    if (first !== TMO) begin
      errors++; $display("FAIL tmo_latency: tmo_err after %0d cycles exp %0d", first, TMO);
    end
    checks++;
    if ({busy, done} !== 2'b00 || done_cnt !== 0 || obs_out_q.size() !== 0) begin
      errors++; $display("FAIL tmo_idle: busy,done %b dones %0d bins %0d exp 00 0 0",
                         {busy, done}, done_cnt, obs_out_q.size());
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++; $display("FAIL tmo_frame_cnt: got %0d exp %0d", frame_cnt, exp_frames);
    end
    repeat (3) cyc();
    checks++;
    if (tmo_err !== 1'b1) begin
      errors++; $display("FAIL tmo_sticky: got %b exp 1", tmo_err);
    end
    do_start();
    checks++;
    if ({tmo_err, busy} !== 2'b01) begin
      errors++; $display("FAIL tmo_clear_by_start: tmo_err,busy got %b exp 01", {tmo_err, busy});
    end
    // Second timeout with start raised on the very edge the timeout fires.
    load_samples(N, 1'b0, 1'b0);
    for (int m = 1; m <= TMO; m++) begin
      if (m == TMO) start = 1'b1;
      cyc();
    end
    start = 1'b0;
    checks++;
    if ({tmo_err, busy} !== 2'b10) begin
      errors++; $display("FAIL tmo_beats_start: tmo_err,busy got %b exp 10", {tmo_err, busy});
    end
    do_start();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if ({tmo_err, busy} !== 2'b00) begin
      errors++; $display("FAIL tmo_restart_abort: tmo_err,busy got %b exp 00", {tmo_err, busy});
    end
  endtask

  task automatic test_abort();
    clear_mon();
    do_start();
    load_samples(5, 1'b0, 1'b0);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    checks++;
    if ({busy, s_ready, fft_ien} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: busy,s_ready,ien got %b exp 000", {busy, s_ready, fft_ien});
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++; $display("FAIL abort_frame_cnt: got %0d exp %0d", frame_cnt, exp_frames);
    end
    abort = 1'b1;
    start = 1'b1;
    fft_oen = 1'b1;
    cyc();
    abort = 1'b0;
    start = 1'b0;
    cyc();
    fft_oen = 1'b0;
    checks++;
    if (busy !== 1'b0 || obs_out_q.size() !== 0) begin
      errors++; $display("FAIL abort_beats_start: busy %b bins %0d exp 0 0", busy, obs_out_q.size());
    end
    clear_mon();
    do_start();
    load_samples(N, 1'b0, 1'b0);
    core_burst(N, 2);
    cyc();
    exp_frames++;
    checks++;
    if (obs_in_q.size() !== N || obs_out_q.size() !== N) begin
      errors++; $display("FAIL abort_restart_sizes: in %0d out %0d exp %0d", obs_in_q.size(), obs_out_q.size(), N);
    end
    for (int i = 0; i < exp_in_q.size() && i < obs_in_q.size(); i++) begin
      checks++;
      if (obs_in_q[i] !== exp_in_q[i]) begin
        errors++; $display("FAIL abort_restart_in[%0d]: got %h exp %h", i, obs_in_q[i], exp_in_q[i]);
      end
    end
    for (int i = 0; i < exp_out_q.size() && i < obs_out_q.size(); i++) begin
      checks++;
      if (obs_out_q[i] !== exp_out_q[i]) begin
        errors++; $display("FAIL abort_restart_out[%0d]: got %h exp %h", i, obs_out_q[i], exp_out_q[i]);
      end
    end
    checks++;
    if (frame_cnt !== 16'(exp_frames)) begin
      errors++; $display("FAIL abort_restart_frame_cnt: got %0d exp %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_continuous();
    clear_mon();
    cont = 1'b1;
    do_start();
    for (int f = 0; f < 3; f++) begin
      load_samples(N, 1'b0, 1'b0);
      if (f == 2) cont = 1'b0;
      core_burst(N, 2);
      exp_frames++;
      checks++;
      if ({m_last, done, s_ready} !== 3'b110) begin
        errors++; $display("FAIL cont_done[%0d]: m_last,done,s_ready got %b exp 110", f, {m_last, done, s_ready});
      end
      checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
        errors++; $display("FAIL cont_frame_cnt[%0d]: got %0d exp %0d", f, frame_cnt, exp_frames);
      end
      cyc();
      checks++;
      if ({busy, s_ready} !== ((f < 2) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL cont_reenter[%0d]: busy,s_ready got %b exp %b", f, {busy, s_ready},
                           ((f < 2) ? 2'b11 : 2'b00));
      end
    end
    checks++;
    if (done_cnt !== 3 || obs_in_q.size() !== 3 * N || obs_out_q.size() !== 3 * N) begin
      errors++; $display("FAIL cont_counts: dones %0d in %0d out %0d exp 3 %0d %0d",
                         done_cnt, obs_in_q.size(), obs_out_q.size(), 3 * N, 3 * N);
    end
    for (int i = 0; i < exp_in_q.size() && i < obs_in_q.size(); i++) begin
      checks++;
      if (obs_in_q[i] !== exp_in_q[i]) begin
        errors++; $display("FAIL cont_in[%0d]: got %h exp %h", i, obs_in_q[i], exp_in_q[i]);
      end
    end
    for (int i = 0; i < exp_out_q.size() && i < obs_out_q.size(); i++) begin
      checks++;
      if (obs_out_q[i] !== exp_out_q[i]) begin
        errors++; $display("FAIL cont_out[%0d]: got %h exp %h", i, obs_out_q[i], exp_out_q[i]);
      end
    end
  endtask

  task automatic test_reset_unload();
    clear_mon();
    do_start();
    load_samples(N, 1'b0, 1'b0);
    core_burst(4, 0);
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({busy, s_ready, fft_ien, m_valid, m_last, done, tmo_err} !== 7'b0) begin
      errors++; $display("FAIL rst_unload_flags: got %b exp 0000000",
                         {busy, s_ready, fft_ien, m_valid, m_last, done, tmo_err});
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++; $display("FAIL rst_unload_frame_cnt: got %0d exp 0", frame_cnt);
    end
    checks++;
    if ({fft_iaddr, fft_iReal, fft_iImag, m_bin, m_real, m_imag} !== '0) begin
      errors++; $display("FAIL rst_unload_data: got %h exp 0",
                         {fft_iaddr, fft_iReal, fft_iImag, m_bin, m_real, m_imag});
    end
    rst_n = 1'b1;
    exp_frames = 0;
    cyc();
    clear_mon();
    for (int i = 0; i < 4; i++) begin
      fft_oen   = 1'b1;
      fft_oReal = RW'($urandom);
      fft_oImag = IW'($urandom);
      s_valid   = 1'b1;
      cyc();
    end
    fft_oen = 1'b0;
    s_valid = 1'b0;
    repeat (2) cyc();
    checks++;
    if (obs_out_q.size() !== 0 || obs_in_q.size() !== 0 || acc_cnt !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL stray_idle: bins %0d samples %0d accepts %0d busy %b exp 0 0 0 0",
                         obs_out_q.size(), obs_in_q.size(), acc_cnt, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_gapped();
    test_timeout();
    test_abort();
    test_continuous();
    test_reset_unload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
